shift_sequencer: RTL

- Upstream control stage for the accumulator shifter register.
- Accepts one accumulator operation per handshake: load, shift-left, shift-right or clear.
- Drives the shifter control pins (ctrl, num_shift, Ls, Rs, clr, set, Reg_in) one bit of shift per cycle, so shifts of any amount 0..7 take a deterministic number of cycles.
- Reports busy and done back to the instruction sequencer.

---
 rtl/shift_sequencer_pkg.sv | 27 ++
 rtl/shift_sequencer_if.sv | 40 ++++
 rtl/shift_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_seq_pkg : op/ctrl encodings and FSM states for shift_sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LOAD  = 2'b01;
  localparam logic [1:0] CTRL_LEFT  = 2'b10;
  localparam logic [1:0] CTRL_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_sequencer_if : request handshake, shifter pins and status      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface shift_sequencer_if #(
  parameter int N     = 8,
  parameter int AMT_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AMT_W-1:0] req_amt;
  logic [N-1:0]     req_data;
  logic             req_fill;
  logic             req_rot;
  logic [N-1:0]     acc_q;
  logic [N-1:0]     sh_data;
  logic [1:0]       sh_ctrl;
  logic [AMT_W-1:0] sh_num;
  logic             sh_ls;
  logic             sh_rs;
  logic             sh_clr_n;
  logic             sh_set_n;
  logic             busy;
  logic             done;

  modport slave (
    input  req_valid, req_op, req_amt, req_data, req_fill, req_rot, acc_q,
    output req_ready, sh_data, sh_ctrl, sh_num, sh_ls, sh_rs, sh_clr_n,
           sh_set_n, busy, done
  );

  modport master (
    output req_valid, req_op, req_amt, req_data, req_fill, req_rot, acc_q,
    input  req_ready, sh_data, sh_ctrl, sh_num, sh_ls, sh_rs, sh_clr_n,
           sh_set_n, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_sequencer : drives accumulator shifter one bit per cycle       |
// | Optional rotate mode: SHIFT_SEQ_ROTATE_EN              Rev 1.0       |
// +----------------------------------------------------------------------+
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int AMT_W = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  shift_sequencer_if.slave bus
);

  state_t           state_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       ctrl_q;
  logic [AMT_W-1:0] num_q;
  logic             ls_q;
  logic             rs_q;
  logic             clr_n_q;
  logic [N-1:0]     data_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rot_q;
`endif

  // Outputs are registered and loaded for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_HOLD;
      num_q   <= '0;
      ls_q    <= 1'b0;
      rs_q    <= 1'b0;
      clr_n_q <= 1'b1;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= bus.req_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= bus.req_rot;
`endif
            case (bus.req_op)
              OP_LOAD: begin
                state_q <= S_LOAD;
                ctrl_q  <= CTRL_LOAD;
                data_q  <= bus.req_data;
              end
              OP_CLR: begin
                state_q <= S_CLEAR;
                clr_n_q <= 1'b0;
              end
              default: begin
                if (bus.req_amt == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_SHIFT;
                  ctrl_q  <= (bus.req_op == OP_SHL) ? CTRL_LEFT : CTRL_RIGHT;
                  num_q   <= AMT_W'(1);
                  ls_q    <= (bus.req_op == OP_SHL) && bus.req_fill;
                  rs_q    <= (bus.req_op == OP_SHR) && bus.req_fill;
                end
              end
            endcase
          end
        end
        S_LOAD, S_CLEAR: begin
          state_q <= S_DONE;
          ctrl_q  <= CTRL_HOLD;
          data_q  <= '0;
          clr_n_q <= 1'b1;
          done_q  <= 1'b1;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q - AMT_W'(1);
          // Last step: counter still shows 1 in this cycle.
          if (cnt_q == AMT_W'(1)) begin
            state_q <= S_DONE;
            ctrl_q  <= CTRL_HOLD;
            num_q   <= '0;
            ls_q    <= 1'b0;
            rs_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ctrl_q  <= CTRL_HOLD;
          num_q   <= '0;
          ls_q    <= 1'b0;
          rs_q    <= 1'b0;
          clr_n_q <= 1'b1;
          data_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.sh_data   = data_q;
  assign bus.sh_ctrl   = ctrl_q;
  assign bus.sh_num    = num_q;
  assign bus.sh_clr_n  = clr_n_q;
  assign bus.sh_set_n  = 1'b1;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef SHIFT_SEQ_ROTATE_EN
  // Rotate feeds back the live accumulator so each step sees the updated value.
  assign bus.sh_ls = (rot_q && ctrl_q == CTRL_LEFT)  ? bus.acc_q[N-1] : ls_q;
  assign bus.sh_rs = (rot_q && ctrl_q == CTRL_RIGHT) ? bus.acc_q[0]   : rs_q;
`else
  assign bus.sh_ls = ls_q;
  assign bus.sh_rs = rs_q;
`endif

endmodule
`default_nettype wire
